// File: rtl/tv_trig_pkg.sv
// Shared constants for the TV trigger controller: state codes, register map,
// source codes and CTRL bit positions.
package tv_trig_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned N_SRC  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_HOLDOFF = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_ROW     = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STAT    = 2'd3;

  localparam logic [1:0] SRC_EVEN    = 2'd0;
  localparam logic [1:0] SRC_ODD     = 2'd1;
  localparam logic [1:0] SRC_ANYROW  = 2'd2;
  localparam logic [1:0] SRC_CERTROW = 2'd3;

  localparam int unsigned CTRL_SRC_LSB = 0;
  localparam int unsigned CTRL_POL     = 2;
  localparam int unsigned CTRL_REARM   = 3;
  localparam int unsigned CTRL_EN      = 4;
  localparam int unsigned CTRL_VMODE   = 5;

endpackage

// File: rtl/tv_trig_edge_sync.sv
// Synchroniser for one asynchronous trigger level, followed by an edge
// register producing registered one-cycle rise and fall pulses.
module tv_trig_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in10M,
  input  logic clrn,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain plus previous-level register and edge pulses
  always_ff @(posedge clk_in10M or negedge clrn) begin
    if (!clrn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_sync;
      r_rise <= w_sync & ~r_prev;
      r_fall <= ~w_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/tv_trig_ctrl.sv
// Arm/fire/holdoff sequencer and register file for the TV trigger path.
// Optional accepted-trigger counter enabled by defining TV_TRIG_CNT_EN.
module tv_trig_ctrl
  import tv_trig_pkg::*;
#(
  parameter int unsigned HOLDOFF_W   = 16,
  parameter int unsigned ROW_W       = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_in10M,
  input  logic              clrn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              even_trig,
  input  logic              odd_trig,
  input  logic              anyrow_trig,
  input  logic              certainrow_trig,
  input  logic              arm,
  input  logic              force_trig,
  output logic              video_mode,
  output logic [ROW_W-1:0]  row_number,
  output logic              trig_out,
  output logic              trig_busy,
  output logic [1:0]        state,
  output logic              miss,
  output logic [CNT_W-1:0]  trig_cnt
);

  logic [CTRL_W-1:0]    r_ctrl;
  logic [HOLDOFF_W-1:0] r_holdoff;
  logic [ROW_W-1:0]     r_row;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [HOLDOFF_W-1:0] r_hcnt;
  logic [HOLDOFF_W-1:0] w_hcnt_nxt;
  logic                 r_trig_out;
  logic                 r_busy;
  logic                 r_miss;
  logic                 w_miss_nxt;

  logic [N_SRC-1:0]     w_trig_in;
  logic [N_SRC-1:0]     w_rise;
  logic [N_SRC-1:0]     w_fall;
  logic [1:0]           w_src;
  logic                 w_pol;
  logic                 w_en;
  logic                 w_rearm;
  logic                 w_evt;
  logic                 w_stat_wr;

  assign w_trig_in[SRC_EVEN]    = even_trig;
  assign w_trig_in[SRC_ODD]     = odd_trig;
  assign w_trig_in[SRC_ANYROW]  = anyrow_trig;
  assign w_trig_in[SRC_CERTROW] = certainrow_trig;

  // One synchroniser/edge detector per input; all run continuously so a
  // source switch never sees a stale edge.
  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    tv_trig_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_in10M(clk_in10M),
      .clrn     (clrn),
      .i_async  (w_trig_in[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  assign w_src     = r_ctrl[CTRL_SRC_LSB +: 2];
  assign w_pol     = r_ctrl[CTRL_POL];
  assign w_rearm   = r_ctrl[CTRL_REARM];
  assign w_en      = r_ctrl[CTRL_EN];
  assign w_evt     = w_pol ? w_fall[w_src] : w_rise[w_src];
  assign w_stat_wr = wr_en && (wr_addr == ADDR_STAT);

  // Host register writes; visible to the sequencer on the following cycle
  always_ff @(posedge clk_in10M or negedge clrn) begin
    if (!clrn) begin
      r_ctrl    <= '0;
      r_holdoff <= '0;
      r_row     <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_CTRL:    r_ctrl    <= wr_data[CTRL_W-1:0];
        ADDR_HOLDOFF: r_holdoff <= HOLDOFF_W'(wr_data);
        ADDR_ROW:     r_row     <= wr_data[ROW_W-1:0];
        default:      ;
      endcase
    end
  end

  // Sequencer next-state, holdoff counter and sticky miss
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_miss_nxt  = r_miss;

    case (r_state)
      ST_IDLE: begin
        if (arm) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_evt || force_trig) w_state_nxt = ST_FIRE;
      end
      ST_FIRE: begin
        w_hcnt_nxt = r_holdoff;
        if (r_holdoff == '0) w_state_nxt = w_rearm ? ST_ARMED : ST_IDLE;
        else                 w_state_nxt = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        w_hcnt_nxt = r_hcnt - HOLDOFF_W'(1);
        if (r_hcnt == HOLDOFF_W'(1)) w_state_nxt = w_rearm ? ST_ARMED : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Disable overrides everything, including a pending fire
    if (!w_en) begin
      w_state_nxt = ST_IDLE;
      w_hcnt_nxt  = '0;
    end

    // A miss recorded this cycle wins over a simultaneous clear
    if (w_stat_wr && wr_data[0]) w_miss_nxt = 1'b0;
    if ((r_state == ST_HOLDOFF) && w_evt) w_miss_nxt = 1'b1;
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge clk_in10M or negedge clrn) begin
    if (!clrn) begin
      r_state    <= ST_IDLE;
      r_hcnt     <= '0;
      r_trig_out <= 1'b0;
      r_busy     <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_trig_out <= (w_state_nxt == ST_FIRE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_miss     <= w_miss_nxt;
    end
  end

`ifdef TV_TRIG_CNT_EN
  logic [CNT_W-1:0] r_trig_cnt;
  logic [CNT_W-1:0] w_trig_cnt_nxt;

  // Accepted-trigger count; a clear and a fire in the same cycle leave 1
  always_comb begin
    w_trig_cnt_nxt = r_trig_cnt;
    if (w_stat_wr && wr_data[1]) w_trig_cnt_nxt = '0;
    if (r_state == ST_FIRE) w_trig_cnt_nxt = w_trig_cnt_nxt + CNT_W'(1);
  end

  // Counter register
  always_ff @(posedge clk_in10M or negedge clrn) begin
    if (!clrn) r_trig_cnt <= '0;
    else       r_trig_cnt <= w_trig_cnt_nxt;
  end

  assign trig_cnt = r_trig_cnt;
`else
  assign trig_cnt = '0;
`endif

  assign video_mode = r_ctrl[CTRL_VMODE];
  assign row_number = r_row;
  assign trig_out   = r_trig_out;
  assign trig_busy  = r_busy;
  assign state      = r_state;
  assign miss       = r_miss;

endmodule

// File: tb/tb_tv_trig_ctrl.sv
// Self-checking bench for tv_trig_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a timestamp-based model.
module tb_tv_trig_ctrl;

  localparam int unsigned HOLDOFF_W   = 16;
  localparam int unsigned ROW_W       = 10;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned E0          = SYNC_STAGES + 1;

  logic             clk_in10M = 1'b0;
  logic             clrn = 1'b0;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_addr = 2'd0;
  logic [15:0]      wr_data = 16'd0;
  logic             even_trig = 1'b0;
  logic             odd_trig = 1'b0;
  logic             anyrow_trig = 1'b0;
  logic             certainrow_trig = 1'b0;
  logic             arm = 1'b0;
  logic             force_trig = 1'b0;
  logic             video_mode;
  logic [ROW_W-1:0] row_number;
  logic             trig_out;
  logic             trig_busy;
  logic [1:0]       state;
  logic             miss;
  logic [15:0]      trig_cnt;

  int n_chk = 0;
  int n_fail = 0;

  tv_trig_ctrl #(
    .HOLDOFF_W  (HOLDOFF_W),
    .ROW_W      (ROW_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_in10M      (clk_in10M),
    .clrn           (clrn),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .even_trig      (even_trig),
    .odd_trig       (odd_trig),
    .anyrow_trig    (anyrow_trig),
    .certainrow_trig(certainrow_trig),
    .arm            (arm),
    .force_trig     (force_trig),
    .video_mode     (video_mode),
    .row_number     (row_number),
    .trig_out       (trig_out),
    .trig_busy      (trig_busy),
    .state          (state),
    .miss           (miss),
    .trig_cnt       (trig_cnt)
  );

  always #50 clk_in10M = ~clk_in10M;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Events come from a level history: a rising event in cycle c means the
  // input was low in cycle c-(S+2) and high in cycle c-(S+1). The sequencer
  // is tracked by an armed flag plus the cycle numbers of the last fire and
  // of the last holdoff cycle.
  logic [5:0]       m_ctrl;
  logic [15:0]      m_hold;
  logic [ROW_W-1:0] m_row;
  logic [7:0]       m_hist [4];
  int               m_cyc;
  int               m_fire_at;
  int               m_hold_end;
  bit               m_armed;
  bit               m_miss;
  logic [15:0]      m_cnt;

  function automatic logic [1:0] m_phase();
    if (m_armed) return 2'd1;
    if (m_cyc == m_fire_at) return 2'd2;
    if ((m_cyc > m_fire_at) && (m_cyc <= m_hold_end)) return 2'd3;
    return 2'd0;
  endfunction

  always @(negedge clk_in10M) begin : model
    logic [1:0]  ph;
    logic [3:0]  lvl;
    logic [1:0]  src;
    logic        evt;
    logic [15:0] exp_cnt;
    if (!clrn) begin
      m_ctrl = '0; m_hold = '0; m_row = '0;
      for (int s = 0; s < 4; s++) m_hist[s] = '0;
      m_cyc = 0; m_fire_at = -10; m_hold_end = -10;
      m_armed = 0; m_miss = 0; m_cnt = '0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_trig_out", 32'(trig_out), 32'd0);
      chk("rst_busy", 32'(trig_busy), 32'd0);
    end else begin
      ph = m_phase();
`ifdef TV_TRIG_CNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 16'd0;
`endif
      chk("m_state", 32'(state), 32'(ph));
      chk("m_trig_out", 32'(trig_out), 32'(ph == 2'd2));
      chk("m_busy", 32'(trig_busy), 32'(ph != 2'd0));
      chk("m_miss", 32'(miss), 32'(m_miss));
      chk("m_trig_cnt", 32'(trig_cnt), 32'(exp_cnt));
      chk("m_video_mode", 32'(video_mode), 32'(m_ctrl[5]));
      chk("m_row", 32'(row_number), 32'(m_row));

      lvl = {certainrow_trig, anyrow_trig, odd_trig, even_trig};
      for (int s = 0; s < 4; s++) m_hist[s] = {m_hist[s][6:0], lvl[s]};
      src = m_ctrl[1:0];
      evt = m_ctrl[2] ? (!m_hist[src][E0] && m_hist[src][E0+1])
                      : (m_hist[src][E0] && !m_hist[src][E0+1]);

      if ((ph == 2'd3) && evt) m_miss = 1;
      else if (wr_en && (wr_addr == 2'd3) && wr_data[0]) m_miss = 0;

      if (wr_en && (wr_addr == 2'd3) && wr_data[1]) m_cnt = '0;
      if (ph == 2'd2) m_cnt = m_cnt + 16'd1;

      if (!m_ctrl[4]) begin
        m_armed = 0; m_fire_at = -10; m_hold_end = -10;
      end else begin
        case (ph)
          2'd0: if (arm) m_armed = 1;
          2'd1: if (evt || force_trig) begin m_armed = 0; m_fire_at = m_cyc + 1; end
          2'd2: if (m_hold == 0) m_armed = m_ctrl[3];
                else m_hold_end = m_cyc + int'(m_hold);
          default: if (m_cyc == m_hold_end) m_armed = m_ctrl[3];
        endcase
      end

      if (wr_en) begin
        case (wr_addr)
          2'd0: m_ctrl = wr_data[5:0];
          2'd1: m_hold = wr_data;
          2'd2: m_row  = wr_data[ROW_W-1:0];
          default: ;
        endcase
      end
      m_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_in10M);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int pulses;
    repeat (3) step();
    clrn = 1'b1;
    step();

    // Odd rising edge, no holdoff: single pulse S+2 cycles after the edge
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0011);
    arm = 1'b1; step(); arm = 1'b0; step();
    @(negedge clk_in10M);
    chk("t1_armed", 32'(state), 32'd1);
    step();
    odd_trig = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in10M);
      chk("t1_trig_at", 32'(trig_out), 32'(i == SYNC_STAGES + 2));
      if (trig_out) pulses++;
      if (i < 7) step();
    end
    chk("t1_one_pulse", 32'(pulses), 32'd1);
    chk("t1_idle", 32'(state), 32'd0);
    step(); odd_trig = 1'b0; step(); odd_trig = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in10M);
      chk("t1_second_edge", 32'(trig_out), 32'd0);
      step();
    end

    // Anyrow, auto re-arm, holdoff 5, pulses every 3 cycles
    wr(2'd1, 16'd5);
    wr(2'd0, 16'h001A);
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 26; i++) begin
      anyrow_trig = ((i % 3) == 0) && (i <= 18);
      @(negedge clk_in10M);
      chk("t2_trig", 32'(trig_out), 32'((i == 4) || (i == 13) || (i == 22)));
      if (i == 5 || i == 9) chk("t2_holdoff", 32'(state), 32'd3);
      if (i == 10) chk("t2_rearmed", 32'(state), 32'd1);
      step();
    end
    chk("t2_miss_set", 32'(miss), 32'd1);
    wr(2'd3, 16'h0001);
    @(negedge clk_in10M);
    chk("t2_miss_clr", 32'(miss), 32'd0);
    step();

    // Force on certain-row source, then force coincident with an event
    wr(2'd0, 16'h0000);
    step();
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0013);
    arm = 1'b1; step(); arm = 1'b0; step();
    @(negedge clk_in10M);
    chk("t3_armed", 32'(state), 32'd1);
    step();
    force_trig = 1'b1;
    @(negedge clk_in10M);
    chk("t3_force_now", 32'(trig_out), 32'd0);
    step();
    force_trig = 1'b0;
    @(negedge clk_in10M);
    chk("t3_force_next", 32'(trig_out), 32'd1);
    step();
    @(negedge clk_in10M);
    chk("t3_idle", 32'(state), 32'd0);
    step();
    wr(2'd0, 16'h001B);
    arm = 1'b1; step(); arm = 1'b0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      certainrow_trig = 1'b1;
      force_trig = (i == 3);
      @(negedge clk_in10M);
      chk("t3_coinc", 32'(trig_out), 32'(i == 4));
      if (trig_out) pulses++;
      step();
    end
    force_trig = 1'b0;
    chk("t3_coinc_once", 32'(pulses), 32'd1);

    // Disable during holdoff, then disable coincident with an event
    wr(2'd1, 16'd20);
    force_trig = 1'b1; step(); force_trig = 1'b0; step(); step();
    @(negedge clk_in10M);
    chk("t4_in_holdoff", 32'(state), 32'd3);
    step();
    wr(2'd0, 16'h000B);
    @(negedge clk_in10M);
    chk("t4_reg_latency", 32'(state), 32'd3);
    step();
    @(negedge clk_in10M);
    chk("t4_idle", 32'(state), 32'd0);
    chk("t4_not_busy", 32'(trig_busy), 32'd0);
    step();
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0018);
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 9; i++) begin
      even_trig = 1'b1;
      wr_en = (i == 2); wr_addr = 2'd0; wr_data = 16'h0008;
      @(negedge clk_in10M);
      chk("t4_disable_beats_evt", 32'(trig_out), 32'd0);
      step();
    end
    wr_en = 1'b0;
    chk("t4_disabled_idle", 32'(state), 32'd0);

    // Reset in the middle of a long holdoff
    wr(2'd2, 16'h02AB);
    wr(2'd1, 16'd100);
    wr(2'd0, 16'h0031);
    @(negedge clk_in10M);
    chk("t5_video_mode", 32'(video_mode), 32'd1);
    chk("t5_row", 32'(row_number), 32'h2AB);
    step();
    arm = 1'b1; step(); arm = 1'b0;
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (5) step();
    @(negedge clk_in10M);
    chk("t5_holdoff", 32'(state), 32'd3);
    step();
    clrn = 1'b0;
    #1;
    chk("t5_rst_state", 32'(state), 32'd0);
    chk("t5_rst_busy", 32'(trig_busy), 32'd0);
    chk("t5_rst_vmode", 32'(video_mode), 32'd0);
    chk("t5_rst_row", 32'(row_number), 32'd0);
    chk("t5_rst_miss", 32'(miss), 32'd0);
    chk("t5_rst_cnt", 32'(trig_cnt), 32'd0);
    repeat (2) step();
    clrn = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_in10M);
      chk("t5_no_pulse", 32'(trig_out), 32'd0);
      step();
    end

`ifdef TV_TRIG_CNT_EN
    // Counter: three forced triggers, then clear
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0018);
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      force_trig = 1'b1; step(); force_trig = 1'b0; step();
    end
    step();
    @(negedge clk_in10M);
    chk("t6_cnt3", 32'(trig_cnt), 32'd3);
    step();
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0002);
    @(negedge clk_in10M);
    chk("t6_cnt_clr", 32'(trig_cnt), 32'd0);
    step();
`endif

    // Randomized traffic checked only by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) even_trig = ~even_trig;
      if ($urandom_range(0, 3) == 0) odd_trig = ~odd_trig;
      if ($urandom_range(0, 2) == 0) anyrow_trig = ~anyrow_trig;
      if ($urandom_range(0, 4) == 0) certainrow_trig = ~certainrow_trig;
      arm = ($urandom_range(0, 7) == 0);
      force_trig = ($urandom_range(0, 31) == 0);
      wr_en = ($urandom_range(0, 11) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      case (wr_addr)
        2'd0: begin
          wr_data = 16'($urandom_range(0, 63));
          if ($urandom_range(0, 4) != 0) wr_data[4] = 1'b1;
        end
        2'd1: wr_data = 16'($urandom_range(0, 6));
        2'd2: wr_data = 16'($urandom);
        default: wr_data = 16'($urandom_range(0, 3));
      endcase
      step();
    end
    wr_en = 1'b0; arm = 1'b0; force_trig = 1'b0;
    step();
    @(negedge clk_in10M);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
